updown_counter_mod: RTL and testbench

Parametrised up/down counter: the next generation of the 3-bit up/down counter used for menu and selection indexing. It adds configurable width, a configurable modulus (MAX_VAL), wrap or saturate mode, synchronous parallel load, and terminal and wrap status flags. It sits beside the button debouncers and drives the selection index of the display/FSM logic. One instance covers every count range the design needs.

---
 rtl/updown_counter_mod.sv | 128 ++++++++++++
 tb/tb_updown_counter_mod.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with a configurable modulus.
// Supports wrap or saturate at the bounds, synchronous clamped load,
// terminal-count flags and a one-cycle wrap pulse. Intended for the
// menu/selection index beside the button debouncers.
module updown_counter_mod #(
  parameter int WIDTH    = 3,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  // All compares and steps are done one bit wider than the count, so that
  // MAX_VAL = 2**WIDTH-1 and oversized load values never alias.
  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_CNT  = MAX_EXT[WIDTH-1:0];
  localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   ZERO_EXT = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH-1:0] ZERO_CNT = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_DEC  = 2'd2,
    OP_INC  = 2'd3
  } op_e;

  op_e              op_s;
  logic [WIDTH:0]   count_ext_s;
  logic [WIDTH:0]   load_ext_s;
  logic [WIDTH:0]   inc_ext_s;
  logic [WIDTH:0]   dec_ext_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic             wrap_nxt_s;
  logic [WIDTH-1:0] count_r;
  logic             wrap_r;

  // Pick the operation for this edge: load beats down, down beats up.
  always_comb begin
    op_s = OP_HOLD;
    if (load) begin
      op_s = OP_LOAD;
    end else if (enable && down) begin
      op_s = OP_DEC;
    end else if (enable && up) begin
      op_s = OP_INC;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Widened operands and the candidate +1 / -1 results.
  always_comb begin
    count_ext_s = {1'b0, count_r};
    load_ext_s  = {1'b0, load_val};
    inc_ext_s   = count_ext_s + ONE_EXT;
    dec_ext_s   = count_ext_s - ONE_EXT;
  end

  // Next count and wrap flag, including clamping and bound handling.
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    case (op_s)
      OP_LOAD: begin
        if (load_ext_s > MAX_EXT) begin
          count_nxt_s = MAX_CNT;
        end else begin
          count_nxt_s = load_val;
        end
      end
      OP_DEC: begin
        if (count_ext_s != ZERO_EXT) begin
          count_nxt_s = dec_ext_s[WIDTH-1:0];
        end else if (SATURATE) begin
          count_nxt_s = count_r;
        end else begin
          count_nxt_s = MAX_CNT;
          wrap_nxt_s  = 1'b1;
        end
      end
      OP_INC: begin
        if (count_ext_s < MAX_EXT) begin
          count_nxt_s = inc_ext_s[WIDTH-1:0];
        end else if (SATURATE) begin
          count_nxt_s = count_r;
        end else begin
          count_nxt_s = ZERO_CNT;
          wrap_nxt_s  = 1'b1;
        end
      end
      OP_HOLD: begin
        count_nxt_s = count_r;
      end
      default: begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
      end
    endcase
  end

  // Count and wrap registers; reset clears both immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= ZERO_CNT;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign out    = count_r;
  assign wrap   = wrap_r;
  assign at_max = (count_r == MAX_CNT);
  assign at_min = (count_r == ZERO_CNT);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed, table-driven bench for updown_counter_mod. Four instances:
// dut0 default (max 7, wrap), dut1 max 5 wrap, dut2 max 5 saturate,
// dut3 max 1 wrap. Expected values are hand-computed per vector.
module tb_updown_counter_mod;

  typedef struct {
    int dut; int rst; int ld; int lv; int en; int up; int dn;
    int eo; int ew; int emx; int emn;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      enable_v = 4'b0;
  logic [3:0]      up_v = 4'b0;
  logic [3:0]      down_v = 4'b0;
  logic [3:0]      load_v = 4'b0;
  logic [3:0][2:0] load_val_v = '{default: 3'd0};
  logic [3:0][2:0] out_v;
  logic [3:0]      at_max_v;
  logic [3:0]      at_min_v;
  logic [3:0]      wrap_v;

  int   vectors = 0;
  int   miscompares = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(3)) dut0 (
    .clk(clk), .reset(reset), .enable(enable_v[0]), .up(up_v[0]), .down(down_v[0]),
    .load(load_v[0]), .load_val(load_val_v[0]), .out(out_v[0]),
    .at_max(at_max_v[0]), .at_min(at_min_v[0]), .wrap(wrap_v[0]));

  updown_counter_mod #(.WIDTH(3), .MAX_VAL(5), .SATURATE(1'b0)) dut1 (
    .clk(clk), .reset(reset), .enable(enable_v[1]), .up(up_v[1]), .down(down_v[1]),
    .load(load_v[1]), .load_val(load_val_v[1]), .out(out_v[1]),
    .at_max(at_max_v[1]), .at_min(at_min_v[1]), .wrap(wrap_v[1]));

  updown_counter_mod #(.WIDTH(3), .MAX_VAL(5), .SATURATE(1'b1)) dut2 (
    .clk(clk), .reset(reset), .enable(enable_v[2]), .up(up_v[2]), .down(down_v[2]),
    .load(load_v[2]), .load_val(load_val_v[2]), .out(out_v[2]),
    .at_max(at_max_v[2]), .at_min(at_min_v[2]), .wrap(wrap_v[2]));

  updown_counter_mod #(.WIDTH(3), .MAX_VAL(1), .SATURATE(1'b0)) dut3 (
    .clk(clk), .reset(reset), .enable(enable_v[3]), .up(up_v[3]), .down(down_v[3]),
    .load(load_v[3]), .load_val(load_val_v[3]), .out(out_v[3]),
    .at_max(at_max_v[3]), .at_min(at_min_v[3]), .wrap(wrap_v[3]));

  function automatic void add(int d, int r, int ld, int lv, int en, int u, int dn,
                              int eo, int ew, int emx, int emn);
    vec_t v;
    v = '{d, r, ld, lv, en, u, dn, eo, ew, emx, emn};
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, int d, int eo, int ew, int emx, int emn);
    vectors++;
    if (int'(out_v[d]) != eo) begin
      miscompares++;
      $display("FAIL %s dut%0d out: got %0d want %0d", nm, d, out_v[d], eo);
    end
    if (int'(wrap_v[d]) != ew) begin
      miscompares++;
      $display("FAIL %s dut%0d wrap: got %0d want %0d", nm, d, wrap_v[d], ew);
    end
    if (int'(at_max_v[d]) != emx) begin
      miscompares++;
      $display("FAIL %s dut%0d at_max: got %0d want %0d", nm, d, at_max_v[d], emx);
    end
    if (int'(at_min_v[d]) != emn) begin
      miscompares++;
      $display("FAIL %s dut%0d at_min: got %0d want %0d", nm, d, at_min_v[d], emn);
    end
  endtask

  task automatic clear_inputs();
    enable_v   = 4'b0;
    up_v       = 4'b0;
    down_v     = 4'b0;
    load_v     = 4'b0;
    load_val_v = '{default: 3'd0};
  endtask

  // Called just after a rising edge; a reset vector pulses reset between edges.
  task automatic apply(vec_t v, string nm);
    clear_inputs();
    if (v.rst != 0) begin
      reset = 1'b1;
      #2;
      check(nm, v.dut, v.eo, v.ew, v.emx, v.emn);
      reset = 1'b0;
      #1;
    end else begin
      enable_v[v.dut]   = v.en[0];
      up_v[v.dut]       = v.up[0];
      down_v[v.dut]     = v.dn[0];
      load_v[v.dut]     = v.ld[0];
      load_val_v[v.dut] = v.lv[2:0];
      @(posedge clk);
      #1;
      check(nm, v.dut, v.eo, v.ew, v.emx, v.emn);
    end
  endtask

  initial begin
    // dut0: reset state, up through wrap, down through wrap, load, mid reset
    //   d  r ld lv en up dn   eo ew mx mn
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0,   1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   4, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   5, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   6, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   7, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0,   0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0,   1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1,   7, 1, 1, 0);
    add(0, 0, 1, 6, 0, 0, 0,   6, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0,   1, 0, 0, 0);
    // dut1: max 5 wrap, down from reset, then load clamp / priority
    add(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 1,   5, 1, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1,   4, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1,   3, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1,   2, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1,   1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 1,   5, 1, 1, 0);
    add(1, 0, 1, 7, 0, 0, 0,   5, 0, 1, 0);
    add(1, 0, 1, 2, 0, 0, 0,   2, 0, 0, 0);
    add(1, 0, 1, 6, 0, 0, 0,   5, 0, 1, 0);
    add(1, 0, 1, 4, 1, 1, 1,   4, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 1,   3, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0,   3, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0,   3, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0,   3, 0, 0, 0);
    // dut2: max 5 saturate, climb and hold, fall and hold
    add(2, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    add(2, 0, 0, 0, 1, 1, 0,   1, 0, 0, 0);
    add(2, 0, 0, 0, 1, 1, 0,   2, 0, 0, 0);
    add(2, 0, 0, 0, 1, 1, 0,   3, 0, 0, 0);
    add(2, 0, 0, 0, 1, 1, 0,   4, 0, 0, 0);
    add(2, 0, 0, 0, 1, 1, 0,   5, 0, 1, 0);
    add(2, 0, 0, 0, 1, 1, 0,   5, 0, 1, 0);
    add(2, 0, 0, 0, 1, 1, 0,   5, 0, 1, 0);
    add(2, 0, 0, 0, 1, 1, 0,   5, 0, 1, 0);
    add(2, 0, 0, 0, 1, 1, 0,   5, 0, 1, 0);
    add(2, 0, 0, 0, 1, 1, 0,   5, 0, 1, 0);
    add(2, 0, 0, 0, 1, 0, 1,   4, 0, 0, 0);
    add(2, 0, 0, 0, 1, 0, 1,   3, 0, 0, 0);
    add(2, 0, 0, 0, 1, 0, 1,   2, 0, 0, 0);
    add(2, 0, 0, 0, 1, 0, 1,   1, 0, 0, 0);
    add(2, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1);
    add(2, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1);
    add(2, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1);
    // dut3: max 1, back-to-back wraps, clamp, reset clears wrap
    add(3, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    add(3, 0, 0, 0, 1, 0, 1,   1, 1, 1, 0);
    add(3, 0, 0, 0, 1, 1, 0,   0, 1, 0, 1);
    add(3, 0, 0, 0, 1, 0, 1,   1, 1, 1, 0);
    add(3, 0, 0, 0, 1, 1, 0,   0, 1, 0, 1);
    add(3, 0, 0, 0, 1, 1, 0,   1, 0, 1, 0);
    add(3, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0);
    add(3, 0, 1, 3, 0, 0, 0,   1, 0, 1, 0);
    add(3, 0, 0, 0, 1, 0, 1,   0, 0, 0, 1);
    add(3, 0, 0, 0, 1, 0, 1,   1, 1, 1, 0);
    add(3, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1);

    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Hand sequence: reset asserted mid-count with up held on dut0.
    clear_inputs();
    load_v[0] = 1'b1;
    load_val_v[0] = 3'd5;
    @(posedge clk);
    #1;
    check("seq_load5", 0, 5, 0, 0, 0);
    load_v[0] = 1'b0;
    enable_v[0] = 1'b1;
    up_v[0] = 1'b1;
    @(posedge clk);
    #1;
    check("seq_up6", 0, 6, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("seq_async_rst", 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    check("seq_rst_held", 0, 0, 0, 0, 1);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("seq_first_up", 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check("seq_second_up", 0, 2, 0, 0, 0);
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
